// File: rtl/line_buffer_rd_sched.sv
// line_buffer_rd_sched
//   Read scheduler / flow controller for a NUM_LINES x LINE_WIDTH line buffer.
//   The write stream passes straight through to the buffer and is gated by
//   in_ready. Complete lines are counted in lines_avail. Once WIN_LINES lines
//   are resident, one pass is emitted: for every column, WIN_LINES vertically
//   adjacent pixels, oldest line first. The oldest line is then retired.
//   Optional statistics counters: define LB_SCHED_STATS_EN.
module line_buffer_rd_sched #(
    parameter int PIXEL_WIDTH = 8,
    parameter int LINE_WIDTH  = 1920,
    parameter int NUM_LINES   = 3,
    parameter int WIN_LINES   = 2
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [PIXEL_WIDTH-1:0]           in_pixel,
    input  logic                             in_valid,
    output logic                             in_ready,
    output logic [PIXEL_WIDTH-1:0]           lb_pixel_in,
    output logic                             lb_pixel_in_valid,
    output logic [$clog2(NUM_LINES)-1:0]     lb_rd_line_sel,
    output logic [$clog2(LINE_WIDTH)-1:0]    lb_rd_col_sel,
    input  logic [PIXEL_WIDTH-1:0]           lb_pixel_out,
    output logic [PIXEL_WIDTH-1:0]           out_pixel,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [$clog2(WIN_LINES):0]       out_tap,
    output logic                             out_last,
    output logic [$clog2(NUM_LINES+1)-1:0]   lines_avail,
    output logic                             busy
`ifdef LB_SCHED_STATS_EN
    ,
    output logic [15:0]                      pass_count,
    output logic [15:0]                      stall_count
`endif
);

    localparam int LSEL_W = $clog2(NUM_LINES);
    localparam int COL_W  = $clog2(LINE_WIDTH);
    localparam int TAP_W  = $clog2(WIN_LINES) + 1;
    localparam int AV_W   = $clog2(NUM_LINES + 1);

    localparam logic [COL_W-1:0]  LAST_COL    = COL_W'(LINE_WIDTH - 1);
    localparam logic [TAP_W-1:0]  LAST_K      = TAP_W'(WIN_LINES - 1);
    localparam logic [LSEL_W-1:0] LAST_LINE   = LSEL_W'(NUM_LINES - 1);
    localparam logic [LSEL_W:0]   NUM_LINES_S = (LSEL_W + 1)'(NUM_LINES);
    localparam logic [AV_W-1:0]   NUM_LINES_A = AV_W'(NUM_LINES);
    localparam logic [AV_W-1:0]   WIN_LINES_A = AV_W'(WIN_LINES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_RETIRE
    } state_t;

    state_t              state_reg;
    logic [COL_W-1:0]    wr_col_reg;
    logic [AV_W-1:0]     lines_avail_reg;
    logic [LSEL_W-1:0]   base_reg;
    logic [COL_W-1:0]    col_reg;
    logic [TAP_W-1:0]    k_reg;
    logic [LSEL_W-1:0]   line_sel_reg;
    logic                out_valid_reg;
    logic                out_last_reg;

    logic                accept;
    logic                line_done;
    logic                retire;
    logic [TAP_W-1:0]    k_inc;
    logic [COL_W-1:0]    col_inc;

    // Physical line holding window row k: the ring starts at base.
    function automatic logic [LSEL_W-1:0] line_of(input logic [LSEL_W-1:0] b,
                                                  input logic [TAP_W-1:0]  k);
        logic [LSEL_W:0] sum;
        sum = {1'b0, b} + (LSEL_W + 1)'(k);
        if (sum >= NUM_LINES_S) begin
            sum = sum - NUM_LINES_S;
        end
        return sum[LSEL_W-1:0];
    endfunction

    // The writer always targets the line after the resident ones, so a full
    // ring must stall the source rather than overwrite unread data.
    assign in_ready          = (lines_avail_reg < NUM_LINES_A);
    assign accept            = in_valid & in_ready;
    assign lb_pixel_in       = in_pixel;
    assign lb_pixel_in_valid = accept;
    assign line_done         = accept && (wr_col_reg == LAST_COL);
    assign retire            = (state_reg == ST_RETIRE);

    assign k_inc   = k_reg + 1'b1;
    assign col_inc = col_reg + 1'b1;

    assign out_pixel      = lb_pixel_out;
    assign out_valid      = out_valid_reg;
    assign out_last       = out_last_reg;
    assign out_tap        = k_reg;
    assign lb_rd_line_sel = line_sel_reg;
    assign lb_rd_col_sel  = col_reg;
    assign lines_avail    = lines_avail_reg;
    assign busy           = (state_reg != ST_IDLE);

    // Shadow of the buffer's write column pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_col_reg <= '0;
        end else if (accept) begin
            wr_col_reg <= (wr_col_reg == LAST_COL) ? '0 : wr_col_reg + 1'b1;
        end
    end

    // Resident line count: +1 on a completed line, -1 on retire, both cancel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lines_avail_reg <= '0;
        end else begin
            case ({line_done, retire})
                2'b10:   lines_avail_reg <= lines_avail_reg + 1'b1;
                2'b01:   lines_avail_reg <= lines_avail_reg - 1'b1;
                default: lines_avail_reg <= lines_avail_reg;
            endcase
        end
    end

    // Pass sequencer: column-major walk of the window, then retire the oldest line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            base_reg      <= '0;
            col_reg       <= '0;
            k_reg         <= '0;
            line_sel_reg  <= '0;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (lines_avail_reg >= WIN_LINES_A) begin
                        state_reg     <= ST_RUN;
                        col_reg       <= '0;
                        k_reg         <= '0;
                        line_sel_reg  <= base_reg;
                        out_valid_reg <= 1'b1;
                        out_last_reg  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (out_ready) begin
                        if (out_last_reg) begin
                            state_reg     <= ST_RETIRE;
                            out_valid_reg <= 1'b0;
                            out_last_reg  <= 1'b0;
                        end else if (k_reg != LAST_K) begin
                            k_reg        <= k_inc;
                            line_sel_reg <= line_of(base_reg, k_inc);
                            out_last_reg <= (col_reg == LAST_COL) && (k_inc == LAST_K);
                        end else begin
                            k_reg        <= '0;
                            col_reg      <= col_inc;
                            line_sel_reg <= base_reg;
                            out_last_reg <= (col_inc == LAST_COL) && (LAST_K == '0);
                        end
                    end
                end
                ST_RETIRE: begin
                    base_reg  <= (base_reg == LAST_LINE) ? '0 : base_reg + 1'b1;
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg     <= ST_IDLE;
                    out_valid_reg <= 1'b0;
                    out_last_reg  <= 1'b0;
                end
            endcase
        end
    end

`ifdef LB_SCHED_STATS_EN
    logic [15:0] pass_count_reg;
    logic [15:0] stall_count_reg;

    assign pass_count  = pass_count_reg;
    assign stall_count = stall_count_reg;

    // Saturating count of completed passes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_count_reg <= '0;
        end else if (retire && (pass_count_reg != 16'hFFFF)) begin
            pass_count_reg <= pass_count_reg + 1'b1;
        end
    end

    // Saturating count of cycles the source was held off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count_reg <= '0;
        end else if (in_valid && !in_ready && (stall_count_reg != 16'hFFFF)) begin
            stall_count_reg <= stall_count_reg + 1'b1;
        end
    end
`endif

endmodule
